// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM encoding,
// frame geometry and the clock-to-baud divider computation.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DATA_BITS = 8;

  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses bit_done on the last count.
// restart forces the count back to 0 so every state starts a fresh period.
module uart_baud_gen #(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo_rd.sv
// 8N1 UART transmitter that pulls bytes straight from a first-word
// fall-through FIFO and sends back-to-back frames with no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for a byte (pops as soon as empty=0)
// START | start bit (0) for one bit period
// DATA  | 8 data bits, LSB first, from the shift register
// STOP  | stop bit (1); last cycle may pop the next byte
module uart_tx_fifo_rd
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] pop_data,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 capture;
  logic                 restart;
  logic                 bit_done;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          capture = 1'b1;
          shreg_d = pop_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Chain straight into the next frame when the FIFO still has data.
        if (bit_done) begin
          if (!empty) begin
            capture = 1'b1;
            shreg_d = pop_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign restart = (state_q == ST_IDLE) || (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign pop     = capture & ~rst;
  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule
